shot_controller: RTL and testbench

SHOT_CONTROLLER -- requirements
Module: shot_controller

---
 rtl/shot_controller.sv | 200 ++++++++++++++++++++
 tb/tb_shot_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// shot_controller
//   Turns debounced key levels into an aimed, power-charged shot.
//   IDLE   -> AIM when all balls have stopped (drawLine) and the game is live.
//   AIM    : left/right step the aim direction once every FRAMES_PER_STEP frames.
//   CHARGE : holding shoot raises power once every POWER_FRAMES frames (max 15).
//   FIRE   : one cycle; pulses lineWriteEnable and presents the shot velocity.
//   WAIT   : holds off until balls move (drawLine low) or WAIT_TIMEOUT frames pass.
//
// Ports
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-cycle pulse per video frame
//   drawLine               : high when all balls are stopped (shot permitted)
//   gameFinished           : high when no further shots are allowed
//   keyLeft/keyRight/keyShoot : debounced active-high key levels
//   lineWriteEnable        : one-cycle pulse in the FIRE cycle
//   aiming                 : high in AIM or CHARGE (combinational from state)
//   aimDir                 : direction index 0..15 (0 = right, 4 = down)
//   power                  : charge level 0..15
//   shotVelX/shotVelY      : signed shot velocity, X right-positive, Y down-positive
module shot_controller #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int POWER_FRAMES    = 3,
    parameter int WAIT_TIMEOUT    = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               drawLine,
    input  logic               gameFinished,
    input  logic               keyLeft,
    input  logic               keyRight,
    input  logic               keyShoot,
    output logic               lineWriteEnable,
    output logic               aiming,
    output logic [3:0]         aimDir,
    output logic [3:0]         power,
    output logic signed [9:0]  shotVelX,
    output logic signed [9:0]  shotVelY
);

    typedef enum logic [2:0] {IDLE, AIM, CHARGE, FIRE, WAIT} stateType;

    localparam logic [7:0] STEP_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] POWER_LAST = 8'(POWER_FRAMES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_TIMEOUT - 1);

    stateType          state, stateNext;
    logic [7:0]        frameCnt, frameCntNext;
    logic [3:0]        aimDirNext, powerNext;
    logic              lweNext;
    logic signed [9:0] velXNext, velYNext;
    logic              keyShootPrev;
    logic              abortReq, shootRise, oneKey;

    // X component of the unit direction table, scaled by 8.
    function automatic logic signed [4:0] dirDx(input logic [3:0] d);
        logic signed [4:0] r;
        r = '0;
        case (d)
            4'd0:  r =  5'sd8;
            4'd1:  r =  5'sd7;
            4'd2:  r =  5'sd6;
            4'd3:  r =  5'sd3;
            4'd4:  r =  5'sd0;
            4'd5:  r = -5'sd3;
            4'd6:  r = -5'sd6;
            4'd7:  r = -5'sd7;
            4'd8:  r = -5'sd8;
            4'd9:  r = -5'sd7;
            4'd10: r = -5'sd6;
            4'd11: r = -5'sd3;
            4'd12: r =  5'sd0;
            4'd13: r =  5'sd3;
            4'd14: r =  5'sd6;
            4'd15: r =  5'sd7;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Direction component times (power+1); |result| <= 8*16 = 128 fits in 10 bits.
    function automatic logic signed [9:0] scaleVel(input logic signed [4:0] comp,
                                                   input logic [3:0]        pw);
        logic signed [9:0] c, m;
        c = {{5{comp[4]}}, comp};
        m = {6'd0, pw} + 10'sd1;
        return c * m;
    endfunction

    function automatic logic [3:0] satIncPower(input logic [3:0] p);
        return (p == 4'd15) ? 4'd15 : p + 4'd1;
    endfunction

    assign aiming    = (state == AIM) || (state == CHARGE);
    assign abortReq  = !drawLine || gameFinished;
    assign shootRise = keyShoot && !keyShootPrev;
    assign oneKey    = keyLeft ^ keyRight;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            frameCnt        <= '0;
            aimDir          <= '0;
            power           <= '0;
            lineWriteEnable <= 1'b0;
            shotVelX        <= '0;
            shotVelY        <= '0;
            keyShootPrev    <= 1'b0;
        end else begin
            state           <= stateNext;
            frameCnt        <= frameCntNext;
            aimDir          <= aimDirNext;
            power           <= powerNext;
            lineWriteEnable <= lweNext;
            shotVelX        <= velXNext;
            shotVelY        <= velYNext;
            keyShootPrev    <= keyShoot;
        end
    end

    // The shot is computed on the CHARGE->FIRE transition so that the pulse
    // and the new velocity appear together in the FIRE cycle.
    always_comb begin
        stateNext    = state;
        frameCntNext = frameCnt;
        aimDirNext   = aimDir;
        powerNext    = power;
        lweNext      = 1'b0;
        velXNext     = shotVelX;
        velYNext     = shotVelY;
        case (state)
            IDLE: begin
                powerNext    = '0;
                frameCntNext = '0;
                if (drawLine && !gameFinished) stateNext = AIM;
            end
            AIM: begin
                if (abortReq) begin
                    stateNext    = IDLE;
                    frameCntNext = '0;
                end else if (shootRise) begin
                    stateNext    = CHARGE;
                    powerNext    = '0;
                    frameCntNext = '0;
                end else if (!oneKey) begin
                    frameCntNext = '0;
                end else if (startOfFrame) begin
                    if (frameCnt == STEP_LAST) begin
                        frameCntNext = '0;
                        aimDirNext   = keyRight ? aimDir + 4'd1 : aimDir - 4'd1;
                    end else begin
                        frameCntNext = frameCnt + 8'd1;
                    end
                end
            end
            CHARGE: begin
                if (abortReq) begin
                    stateNext    = IDLE;
                    frameCntNext = '0;
                end else if (!keyShoot) begin
                    stateNext    = FIRE;
                    frameCntNext = '0;
                    lweNext      = 1'b1;
                    velXNext     = scaleVel(dirDx(aimDir), power);
                    // DY table is the DX table rotated by a quarter turn.
                    velYNext     = scaleVel(dirDx(aimDir - 4'd4), power);
                end else if (startOfFrame) begin
                    if (frameCnt == POWER_LAST) begin
                        frameCntNext = '0;
                        powerNext    = satIncPower(power);
                    end else begin
                        frameCntNext = frameCnt + 8'd1;
                    end
                end
            end
            FIRE: begin
                stateNext    = WAIT;
                frameCntNext = '0;
            end
            WAIT: begin
                if (!drawLine) begin
                    stateNext    = IDLE;
                    frameCntNext = '0;
                end else if (startOfFrame) begin
                    if (frameCnt == WAIT_LAST) begin
                        stateNext    = IDLE;
                        frameCntNext = '0;
                    end else begin
                        frameCntNext = frameCnt + 8'd1;
                    end
                end
            end
            default: begin
                stateNext    = IDLE;
                frameCntNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_shot_controller.sv
// Testbench for shot_controller: directed key/frame sequences, a behavioural
// reference checked every cycle, plus literal expectations for key scenarios.
module tb_shot_controller;

    localparam int FPS = 4;
    localparam int PF  = 3;
    localparam int WT  = 8;

    localparam int M_IDLE   = 0;
    localparam int M_AIM    = 1;
    localparam int M_CHARGE = 2;
    localparam int M_FIRE   = 3;
    localparam int M_WAIT   = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic drawLine = 1'b0;
    logic gameFinished = 1'b0;
    logic keyLeft = 1'b0;
    logic keyRight = 1'b0;
    logic keyShoot = 1'b0;
    logic              lineWriteEnable;
    logic              aiming;
    logic [3:0]        aimDir;
    logic [3:0]        power;
    logic signed [9:0] shotVelX;
    logic signed [9:0] shotVelY;

    int nChecks = 0;
    int nErrors = 0;
    int lweCount = 0;

    int DX[16] = '{8, 7, 6, 3, 0, -3, -6, -7, -8, -7, -6, -3, 0, 3, 6, 7};
    int DY[16] = '{0, 3, 6, 7, 8, 7, 6, 3, 0, -3, -6, -7, -8, -7, -6, -3};

    int         mMode = M_IDLE;
    int         mDir = 0;
    int         mPow = 0;
    int         mRun = 0;
    int         mCharge = 0;
    int         mWait = 0;
    bit         mLwe = 1'b0;
    bit         mPrev = 1'b0;
    bit         mReady = 1'b0;
    logic [9:0] mVx = '0;
    logic [9:0] mVy = '0;

    always #5 clk = ~clk;

    shot_controller #(
        .FRAMES_PER_STEP(FPS),
        .POWER_FRAMES(PF),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .drawLine(drawLine),
        .gameFinished(gameFinished),
        .keyLeft(keyLeft),
        .keyRight(keyRight),
        .keyShoot(keyShoot),
        .lineWriteEnable(lineWriteEnable),
        .aiming(aiming),
        .aimDir(aimDir),
        .power(power),
        .shotVelX(shotVelX),
        .shotVelY(shotVelY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: aim steps counted as whole multiples of FPS frames
    // held, power as whole multiples of PF frames charged (capped at 15).
    task automatic modelStep();
        bit rise;
        bit abortNow;
        if (!resetN) begin
            mMode = M_IDLE; mDir = 0; mPow = 0; mRun = 0; mCharge = 0; mWait = 0;
            mLwe = 1'b0; mPrev = 1'b0; mVx = '0; mVy = '0; mReady = 1'b1;
        end else begin
            rise     = keyShoot && !mPrev;
            mPrev    = keyShoot;
            abortNow = !drawLine || gameFinished;
            mLwe     = 1'b0;
            case (mMode)
                M_IDLE: begin
                    mPow = 0;
                    if (drawLine && !gameFinished) begin
                        mMode = M_AIM;
                        mRun  = 0;
                    end
                end
                M_AIM: begin
                    if (abortNow) mMode = M_IDLE;
                    else if (rise) begin
                        mMode = M_CHARGE; mPow = 0; mCharge = 0;
                    end else if (keyLeft != keyRight) begin
                        if (startOfFrame) begin
                            mRun++;
                            if (mRun % FPS == 0) mDir = (mDir + (keyRight ? 1 : 15)) % 16;
                        end
                    end else mRun = 0;
                end
                M_CHARGE: begin
                    if (abortNow) mMode = M_IDLE;
                    else if (!keyShoot) begin
                        mMode = M_FIRE;
                        mLwe  = 1'b1;
                        mVx   = 10'(DX[mDir] * (mPow + 1));
                        mVy   = 10'(DY[mDir] * (mPow + 1));
                    end else if (startOfFrame) begin
                        mCharge++;
                        mPow = (mCharge / PF > 15) ? 15 : mCharge / PF;
                    end
                end
                M_FIRE: begin
                    mMode = M_WAIT;
                    mWait = 0;
                end
                default: begin
                    if (!drawLine) mMode = M_IDLE;
                    else if (startOfFrame) begin
                        mWait++;
                        if (mWait == WT) mMode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            modelStep();
        end
    end

    // Per-cycle comparison, sampled on the inactive clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mReady) begin
                chk("lineWriteEnable", {31'd0, lineWriteEnable}, {31'd0, mLwe});
                chk("aiming", {31'd0, aiming}, {31'd0, (mMode == M_AIM || mMode == M_CHARGE)});
                chk("aimDir", {28'd0, aimDir}, mDir);
                chk("power", {28'd0, power}, mPow);
                chk("shotVelX", {22'd0, $unsigned(shotVelX)}, {22'd0, mVx});
                chk("shotVelY", {22'd0, $unsigned(shotVelY)}, {22'd0, mVy});
                if (lineWriteEnable === 1'b1) lweCount++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
            tick();
            tick();
        end
    endtask

    initial begin
        drawLine = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset lwe", {31'd0, lineWriteEnable}, 0);
        chk("reset aiming", {31'd0, aiming}, 0);
        chk("reset aimDir", {28'd0, aimDir}, 0);
        chk("reset power", {28'd0, power}, 0);
        chk("reset velX", {22'd0, $unsigned(shotVelX)}, 0);
        chk("reset velY", {22'd0, $unsigned(shotVelY)}, 0);
        tick();
        resetN = 1'b1;
        tick();
        @(negedge clk);
        chk("aim after release", {31'd0, aiming}, 1);

        keyRight = 1'b1;
        frames(8);
        @(negedge clk);
        chk("aimDir right x8", {28'd0, aimDir}, 2);
        keyRight = 1'b0;
        keyLeft  = 1'b1;
        frames(12);
        @(negedge clk);
        chk("aimDir left wrap", {28'd0, aimDir}, 15);
        keyLeft  = 1'b0;
        keyRight = 1'b1;
        frames(12);
        @(negedge clk);
        chk("aimDir right wrap", {28'd0, aimDir}, 2);
        keyLeft = 1'b1;
        frames(8);
        @(negedge clk);
        chk("aimDir both keys", {28'd0, aimDir}, 2);
        keyLeft  = 1'b0;
        keyRight = 1'b0;

        keyShoot = 1'b1;
        tick();
        frames(9);
        @(negedge clk);
        chk("power after 9 frames", {28'd0, power}, 3);
        keyShoot = 1'b0;
        tick();
        @(negedge clk);
        chk("shot1 lwe", {31'd0, lineWriteEnable}, 1);
        chk("shot1 velX", {22'd0, $unsigned(shotVelX)}, 24);
        chk("shot1 velY", {22'd0, $unsigned(shotVelY)}, 24);
        tick();
        @(negedge clk);
        chk("shot1 lwe drops", {31'd0, lineWriteEnable}, 0);

        keyShoot = 1'b1;
        frames(7);
        @(negedge clk);
        chk("wait after 7 frames", {31'd0, aiming}, 0);
        frames(1);
        @(negedge clk);
        chk("aim after timeout", {31'd0, aiming}, 1);
        chk("power cleared in idle", {28'd0, power}, 0);
        frames(6);
        @(negedge clk);
        chk("held shoot no charge", {28'd0, power}, 0);

        keyShoot = 1'b0;
        keyRight = 1'b1;
        frames(40);
        @(negedge clk);
        chk("aimDir to 12", {28'd0, aimDir}, 12);
        chk("model pin dir", mDir, 12);
        keyRight = 1'b0;
        keyShoot = 1'b1;
        tick();
        frames(60);
        @(negedge clk);
        chk("power saturates", {28'd0, power}, 15);
        chk("model pin power", mPow, 15);
        keyShoot = 1'b0;
        tick();
        @(negedge clk);
        chk("shot2 lwe", {31'd0, lineWriteEnable}, 1);
        chk("shot2 velX", {22'd0, $unsigned(shotVelX)}, 0);
        chk("shot2 velY", {22'd0, $unsigned(shotVelY)}, 32'h380);

        tick();
        drawLine = 1'b0;
        tick();
        @(negedge clk);
        chk("wait exits on drawLine low", {31'd0, aiming}, 0);
        drawLine = 1'b1;
        tick();
        keyShoot = 1'b1;
        tick();
        frames(4);
        @(negedge clk);
        chk("charge before abort", {28'd0, power}, 1);
        gameFinished = 1'b1;
        tick();
        @(negedge clk);
        chk("abort aiming", {31'd0, aiming}, 0);
        chk("abort lwe", {31'd0, lineWriteEnable}, 0);
        chk("abort velY kept", {22'd0, $unsigned(shotVelY)}, 32'h380);
        keyShoot = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("gameFinished holds idle", {31'd0, aiming}, 0);
        chk("lwe pulse count", lweCount, 2);

        gameFinished = 1'b0;
        tick();
        drawLine = 1'b0;
        keyShoot = 1'b1;
        tick();
        @(negedge clk);
        chk("abort beats shoot edge", {31'd0, aiming}, 0);

        keyShoot = 1'b0;
        drawLine = 1'b1;
        tick();
        tick();
        keyShoot = 1'b1;
        tick();
        frames(2);
        resetN   = 1'b0;
        keyShoot = 1'b0;
        @(negedge clk);
        chk("reset in charge aiming", {31'd0, aiming}, 0);
        chk("reset in charge aimDir", {28'd0, aimDir}, 0);
        tick();
        tick();
        resetN = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("aim after second reset", {31'd0, aiming}, 1);
        chk("no pulse after reset", lweCount, 2);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
